// File: rtl/dbus_responder.sv
// Data-bus responder backed by a local word-addressed SRAM model.
// Answers each accepted request after LATENCY cycles, with one data_ok pulse per transaction.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_responder
    import dbus_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [63:0] BASE      = 64'h8000_0000,
    parameter int          LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [63:0] data_q;
    logic        accept;
    logic        addr_ok;
    logic        data_ok;

    logic [63:0] mem [DEPTH];

    logic [63:0]      offset;
    logic [IDX_W-1:0] index;
    logic             in_range;
    logic             is_write;

    assign offset   = dreq.addr - BASE;
    assign index    = offset[IDX_W+2:3];
    assign in_range = (dreq.addr >= BASE) && (dreq.addr < LIMIT);
    assign is_write = |dreq.strobe;

    logic unused_bits;
    assign unused_bits = ^{offset[63:IDX_W+3], offset[2:0], dreq.size};

    // State, countdown and response data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            data_q <= 64'h0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                data_q <= (!is_write && in_range) ? mem[index] : 64'h0;
            end
        end
    end

    // The array survives reset, so it is written outside the reset block
    always_ff @(posedge clk) begin
        if (accept && is_write && in_range) begin
            for (int j = 0; j < 8; j++) begin
                if (dreq.strobe[j]) begin
                    mem[index][8*j +: 8] <= dreq.data[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so a request held during reset is never acknowledged
                addr_ok = dreq.valid && reset;
                if (dreq.valid) begin
                    accept  = 1'b1;
                    cnt_n   = 4'(LATENCY - 1);
                    state_n = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                data_ok = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign dresp.addr_ok = addr_ok;
    assign dresp.data_ok = data_ok;
    assign dresp.data    = data_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: three instances at LATENCY 1, 2 and 3 sharing one
// request bus, with valid routed only to the instance under test.
module tb_dbus_responder;
    import dbus_pkg::*;

    logic       clk;
    logic       reset;
    int         sel;
    dbus_req_t  dreq;
    dbus_req_t  dreq1, dreq2, dreq3;
    dbus_resp_t dresp1, dresp2, dresp3, cur;

    int vectors;
    int miscompares;

    dbus_responder #(.LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1));
    dbus_responder #(.LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .dreq(dreq2), .dresp(dresp2));
    dbus_responder #(.LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .dreq(dreq3), .dresp(dresp3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dreq1 = dreq;
        dreq2 = dreq;
        dreq3 = dreq;
        dreq1.valid = dreq.valid && (sel == 1);
        dreq2.valid = dreq.valid && (sel == 2);
        dreq3.valid = dreq.valid && (sel == 3);
        case (sel)
            1:       cur = dresp1;
            3:       cur = dresp3;
            default: cur = dresp2;
        endcase
    end

    // Called at posedge+1; returns at posedge+1 just after the RESP cycle with valid still high.
    task automatic xfer(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                        output logic [63:0] rd, output int lat, output logic aok,
                        output logic aok_late);
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'd3;
        dreq.strobe = s;
        dreq.data   = d;
        lat         = -1;
        rd          = 64'hx;
        aok_late    = 1'b0;
        @(negedge clk);
        aok = cur.addr_ok;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cur.addr_ok) aok_late = 1'b1;
            if (cur.data_ok) begin
                lat = i;
                rd  = cur.data;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        dreq.valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel        = 2;
        dreq.valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (cur.addr_ok !== 1'b0 || cur.data_ok !== 1'b0 || cur.data !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got addr_ok=%b data_ok=%b data=%h, want 0/0/0",
                         c, cur.addr_ok, cur.data_ok, cur.data);
            end
        end
        @(posedge clk);
        #1;
        dreq.valid = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rw_latency2();
        logic [63:0] rd;
        int          lat;
        logic        aok, late;
        sel = 2;
        xfer(64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, rd, lat, aok, late);
        vectors++;
        if (aok !== 1'b1 || lat != 2 || late !== 1'b0 || rd !== 64'h0) begin
            miscompares++;
            $display("FAIL write_l2: got addr_ok=%b lat=%0d late_addr_ok=%b data=%h, want 1/2/0/0",
                     aok, lat, late, rd);
        end
        dreq.valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (cur.data_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL data_ok_single_pulse: got %b, want 0", cur.data_ok);
        end
        @(posedge clk);
        #1;
        xfer(64'h8000_0008, 8'h00, 64'h0, rd, lat, aok, late);
        vectors++;
        if (aok !== 1'b1 || lat != 2 || rd !== 64'h1122_3344_5566_7788) begin
            miscompares++;
            $display("FAIL read_l2: got addr_ok=%b lat=%0d data=%h, want 1/2/1122334455667788",
                     aok, lat, rd);
        end
        idle_cycle();
    endtask

    task automatic test_partial_write();
        logic [63:0] rd;
        int          lat;
        logic        aok, late;
        sel = 2;
        xfer(64'h8000_0008, 8'h0F, 64'hAAAA_AAAA_DEAD_BEEF, rd, lat, aok, late);
        xfer(64'h8000_0008, 8'h00, 64'h0, rd, lat, aok, late);
        vectors++;
        if (lat != 2 || rd !== 64'h1122_3344_DEAD_BEEF) begin
            miscompares++;
            $display("FAIL partial_write: got lat=%0d data=%h, want 2/11223344deadbeef", lat, rd);
        end
        idle_cycle();
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd;
        int          lat;
        logic        aok, late;
        sel = 2;
        xfer(64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, lat, aok, late);
        xfer(64'h8000_1FF8, 8'hFF, 64'hFEDC_BA98_7654_3210, rd, lat, aok, late);
        xfer(64'h7FFF_FFF8, 8'hFF, 64'h5555_5555_5555_5555, rd, lat, aok, late);
        vectors++;
        if (aok !== 1'b1 || lat != 2) begin
            miscompares++;
            $display("FAIL oor_write_low: got addr_ok=%b lat=%0d, want 1/2", aok, lat);
        end
        xfer(64'h8000_2000, 8'hFF, 64'h6666_6666_6666_6666, rd, lat, aok, late);
        vectors++;
        if (aok !== 1'b1 || lat != 2) begin
            miscompares++;
            $display("FAIL oor_write_high: got addr_ok=%b lat=%0d, want 1/2", aok, lat);
        end
        xfer(64'h7FFF_FFF8, 8'h00, 64'h0, rd, lat, aok, late);
        vectors++;
        if (lat != 2 || rd !== 64'h0) begin
            miscompares++;
            $display("FAIL oor_read_low: got lat=%0d data=%h, want 2/0", lat, rd);
        end
        xfer(64'h8000_2000, 8'h00, 64'h0, rd, lat, aok, late);
        vectors++;
        if (lat != 2 || rd !== 64'h0) begin
            miscompares++;
            $display("FAIL oor_read_high: got lat=%0d data=%h, want 2/0", lat, rd);
        end
        xfer(64'h8000_0000, 8'h00, 64'h0, rd, lat, aok, late);
        vectors++;
        if (rd !== 64'h0123_4567_89AB_CDEF) begin
            miscompares++;
            $display("FAIL word0_intact: got %h, want 0123456789abcdef", rd);
        end
        xfer(64'h8000_1FF8, 8'h00, 64'h0, rd, lat, aok, late);
        vectors++;
        if (rd !== 64'hFEDC_BA98_7654_3210) begin
            miscompares++;
            $display("FAIL word_last_intact: got %h, want fedcba9876543210", rd);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd;
        int          lat;
        int          extra;
        logic        aok, late;
        logic [63:0] pat [4];
        pat[0] = 64'h1000_0000_0000_0001;
        pat[1] = 64'h2000_0000_0000_0002;
        pat[2] = 64'h3000_0000_0000_0003;
        pat[3] = 64'h4000_0000_0000_0004;
        sel = 1;
        for (int w = 0; w < 4; w++) begin
            xfer(64'h8000_0000 + 64'(w * 8), 8'hFF, pat[w], rd, lat, aok, late);
        end
        idle_cycle();
        for (int w = 0; w < 4; w++) begin
            xfer(64'h8000_0000 + 64'(w * 8), 8'h00, 64'h0, rd, lat, aok, late);
            vectors++;
            if (aok !== 1'b1 || lat != 1 || rd !== pat[w]) begin
                miscompares++;
                $display("FAIL b2b_read word %0d: got addr_ok=%b lat=%0d data=%h, want 1/1/%h",
                         w, aok, lat, rd, pat[w]);
            end
        end
        dreq.valid = 1'b0;
        extra      = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cur.data_ok) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: got %0d extra pulses, want 0", extra);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_txn();
        logic [63:0] rd;
        int          lat;
        int          pulses;
        logic        aok, late;
        sel = 3;
        xfer(64'h8000_0028, 8'hFF, 64'hCAFE_F00D_1234_5678, rd, lat, aok, late);
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL write_l3: got lat=%0d, want 3", lat);
        end
        idle_cycle();
        dreq.valid  = 1'b1;
        dreq.strobe = 8'h00;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cur.data_ok) pulses++;
            if (c == 1) dreq.valid = 1'b0;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (cur.data_ok) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_abort: got %0d data_ok pulses, want 0", pulses);
        end
        @(posedge clk);
        #1;
        xfer(64'h8000_0028, 8'h00, 64'h0, rd, lat, aok, late);
        vectors++;
        if (aok !== 1'b1 || lat != 3 || rd !== 64'hCAFE_F00D_1234_5678) begin
            miscompares++;
            $display("FAIL read_after_reset: got addr_ok=%b lat=%0d data=%h, want 1/3/cafef00d12345678",
                     aok, lat, rd);
        end
        idle_cycle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        sel         = 2;
        dreq        = '0;
        test_reset();
        test_rw_latency2();
        test_partial_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_txn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
